// File: rtl/baud_gen_os_if.sv
// Control and tick bundle between the baud generator and its UART users.
// The master side drives enable, divisor and resync; the slave side returns ticks.
interface baud_gen_os_if #(
  parameter int DIV_W = 16
);
  logic             en;
  logic [DIV_W-1:0] div_in;
  logic             resync;
  logic             os_tick;
  logic             mid_tick;
  logic             baud_tick;
  logic [DIV_W-1:0] div_active;

  modport master (
    output en, div_in, resync,
    input  os_tick, mid_tick, baud_tick, div_active
  );

  modport slave (
    input  en, div_in, resync,
    output os_tick, mid_tick, baud_tick, div_active
  );
endinterface

// File: rtl/baud_gen_os.sv
// Programmable oversampling baud generator: os_tick every div clocks, plus mid-bit
// and end-of-bit ticks within each group of OVERSAMPLE os_ticks, with phase resync.
module baud_gen_os #(
  parameter int DIV_W      = 16,
  parameter int OVERSAMPLE = 16,
  parameter int RST_DIV    = 20
) (
  input logic          clk,
  input logic          rst,
  baud_gen_os_if.slave bus
);

  localparam int SUB_W = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
  localparam logic [DIV_W-1:0] RST_DIV_CLAMP = (RST_DIV == 0) ? DIV_W'(1) : DIV_W'(RST_DIV);
  localparam logic [SUB_W-1:0] SUB_LAST = SUB_W'(OVERSAMPLE - 1);
  localparam logic [SUB_W-1:0] SUB_MID  = SUB_W'(OVERSAMPLE / 2 - 1);

  logic [DIV_W-1:0] pre_cnt;
  logic [DIV_W-1:0] div_active_q;
  logic [DIV_W-1:0] div_eff;
  logic [DIV_W-1:0] div_last;
  logic [SUB_W-1:0] sub_cnt;
  logic             wrap;
  logic             os_q;
  logic             mid_q;
  logic             baud_q;

  // The >= compare lets a shrunken divisor recover without running through the counter range.
  always_comb begin
    div_eff  = (div_active_q == '0) ? DIV_W'(1) : div_active_q;
    div_last = div_eff - DIV_W'(1);
    wrap     = (pre_cnt >= div_last);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre_cnt      <= '0;
      sub_cnt      <= '0;
      div_active_q <= RST_DIV_CLAMP;
      os_q         <= 1'b0;
      mid_q        <= 1'b0;
      baud_q       <= 1'b0;
    end else if (!bus.en) begin
      pre_cnt      <= '0;
      sub_cnt      <= '0;
      div_active_q <= bus.div_in;
      os_q         <= 1'b0;
      mid_q        <= 1'b0;
      baud_q       <= 1'b0;
    end else if (bus.resync) begin
      pre_cnt <= '0;
      sub_cnt <= '0;
      os_q    <= 1'b0;
      mid_q   <= 1'b0;
      baud_q  <= 1'b0;
    end else if (wrap) begin
      // A new divisor is only adopted here so every os_tick period is whole.
      pre_cnt      <= '0;
      sub_cnt      <= (sub_cnt == SUB_LAST) ? '0 : sub_cnt + SUB_W'(1);
      div_active_q <= bus.div_in;
      os_q         <= 1'b1;
      mid_q        <= (sub_cnt == SUB_MID);
      baud_q       <= (sub_cnt == SUB_LAST);
    end else begin
      pre_cnt <= pre_cnt + DIV_W'(1);
      os_q    <= 1'b0;
      mid_q   <= 1'b0;
      baud_q  <= 1'b0;
    end
  end

  assign bus.os_tick    = os_q;
  assign bus.mid_tick   = mid_q;
  assign bus.baud_tick  = baud_q;
  assign bus.div_active = div_active_q;

endmodule

// File: tb/tb_baud_gen_os.sv
// Scoreboard bench for baud_gen_os: expected tick/divisor records are queued per cycle
// when stimulus is applied and compared when the DUT reaches that cycle.
module tb_baud_gen_os;

  typedef struct {
    int at;
    int ticks;
    int div;
  } exp_t;

  logic  clk = 1'b0;
  logic  rst;
  int    cyc = 0;
  int    pass_cnt = 0;
  int    total_cnt = 0;
  string phase = "reset";
  exp_t  expq[4][$];

  baud_gen_os_if #(.DIV_W(16)) main_if();
  baud_gen_os_if #(.DIV_W(8))  sw2_if();
  baud_gen_os_if #(.DIV_W(8))  sw3_if();
  baud_gen_os_if #(.DIV_W(8))  sw8_if();

  baud_gen_os #(.DIV_W(16), .OVERSAMPLE(16), .RST_DIV(20)) dut (
    .clk(clk), .rst(rst), .bus(main_if)
  );
  baud_gen_os #(.DIV_W(8), .OVERSAMPLE(2), .RST_DIV(255)) dut_os2 (
    .clk(clk), .rst(rst), .bus(sw2_if)
  );
  baud_gen_os #(.DIV_W(8), .OVERSAMPLE(3), .RST_DIV(255)) dut_os3 (
    .clk(clk), .rst(rst), .bus(sw3_if)
  );
  baud_gen_os #(.DIV_W(8), .OVERSAMPLE(8), .RST_DIV(255)) dut_os8 (
    .clk(clk), .rst(rst), .bus(sw8_if)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int osOf(input int d);
    case (d)
      0:       return 16;
      1:       return 2;
      2:       return 3;
      default: return 8;
    endcase
  endfunction

  // Tick code: os=4, mid=2, baud=1; os tick number j (1-based) since the last phase reset.
  function automatic int tickCode(input int d, input int j);
    int n;
    n = osOf(d);
    return 4 + ((j % n == n / 2) ? 2 : 0) + ((j % n == 0) ? 1 : 0);
  endfunction

  function automatic void sample(input int d, output int ticks, output int div);
    case (d)
      0: begin
        ticks = {29'd0, main_if.os_tick, main_if.mid_tick, main_if.baud_tick};
        div   = int'(main_if.div_active);
      end
      1: begin
        ticks = {29'd0, sw2_if.os_tick, sw2_if.mid_tick, sw2_if.baud_tick};
        div   = int'(sw2_if.div_active);
      end
      2: begin
        ticks = {29'd0, sw3_if.os_tick, sw3_if.mid_tick, sw3_if.baud_tick};
        div   = int'(sw3_if.div_active);
      end
      default: begin
        ticks = {29'd0, sw8_if.os_tick, sw8_if.mid_tick, sw8_if.baud_tick};
        div   = int'(sw8_if.div_active);
      end
    endcase
  endfunction

  function automatic void pushRec(input int d, input int at, input int ticks, input int div);
    exp_t e;
    e.at = at;
    e.ticks = ticks;
    e.div = div;
    expq[d].push_back(e);
  endfunction

  function automatic void pushTick(input int d, input int at, input int j,
                                   input int div_before, input int div_at);
    pushRec(d, at - 1, 0, div_before);
    pushRec(d, at, tickCode(d, j), div_at);
  endfunction

  function automatic int pending();
    int s;
    s = 0;
    for (int d = 0; d < 4; d++) s += expq[d].size();
    return s;
  endfunction

  task automatic checkOutput(input string tag, input int observed, input int expected);
    total_cnt++;
    if (observed == expected) pass_cnt++;
    else $display("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
  endtask

  // Drops en for one edge (clearing counters and loading div_v), then runs from cycle e0.
  task automatic applyStimulus(input int div_v, output int e0);
    main_if.div_in = 16'(div_v);
    main_if.en = 1'b0;
    @(negedge clk);
    e0 = cyc;
    main_if.en = 1'b1;
  endtask

  task automatic waitCycle(input int target);
    while (cyc < target) @(negedge clk);
  endtask

  task automatic waitDrain(input int budget);
    int left;
    for (int i = 0; i < budget && pending() > 0; i++) @(negedge clk);
    left = pending();
    if (left != 0) begin
      checkOutput({phase, "_drain_timeout"}, left, 0);
      for (int d = 0; d < 4; d++) expq[d].delete();
    end
  endtask

  always @(negedge clk) begin
    int   obs_t;
    int   obs_d;
    exp_t e;
    for (int d = 0; d < 4; d++) begin
      while (expq[d].size() > 0 && expq[d][0].at <= cyc) begin
        e = expq[d].pop_front();
        sample(d, obs_t, obs_d);
        if (e.at < cyc) begin
          checkOutput($sformatf("%s_d%0d_late_c%0d", phase, d, e.at), cyc, e.at);
        end else begin
          checkOutput($sformatf("%s_d%0d_ticks_c%0d", phase, d, e.at), obs_t, e.ticks);
          checkOutput($sformatf("%s_d%0d_div_c%0d", phase, d, e.at), obs_d, e.div);
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int e0;
    int e1;
    int obs_t;
    int obs_d;

    rst = 1'b1;
    main_if.en = 1'b0;
    main_if.div_in = 16'd20;
    main_if.resync = 1'b0;
    sw2_if.en = 1'b0; sw2_if.div_in = 8'd255; sw2_if.resync = 1'b0;
    sw3_if.en = 1'b0; sw3_if.div_in = 8'd255; sw3_if.resync = 1'b0;
    sw8_if.en = 1'b0; sw8_if.div_in = 8'd255; sw8_if.resync = 1'b0;

    @(negedge clk);
    for (int d = 0; d < 4; d++) begin
      sample(d, obs_t, obs_d);
      checkOutput($sformatf("reset_ticks_d%0d", d), obs_t, 0);
      checkOutput($sformatf("reset_div_d%0d", d), obs_d, (d == 0) ? 20 : 255);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    phase = "run20";
    applyStimulus(20, e0);
    for (int j = 1; j <= 32; j++) pushTick(0, e0 + 20 * j, j, 20, 20);
    waitDrain(700);

    // 20 -> 5 halfway through a period, then 5 -> 20 right after a wrap.
    phase = "divchg";
    applyStimulus(20, e0);
    pushTick(0, e0 + 20, 1, 20, 5);
    for (int j = 2; j <= 16; j++) pushTick(0, e0 + 20 + 5 * (j - 1), j, 5, 5);
    e1 = e0 + 95;
    pushTick(0, e1 + 5, 17, 5, 20);
    pushTick(0, e1 + 25, 18, 20, 20);
    waitCycle(e0 + 10);
    main_if.div_in = 16'd5;
    waitCycle(e1);
    main_if.div_in = 16'd20;
    waitDrain(100);

    phase = "div0";
    applyStimulus(0, e0);
    for (int j = 1; j <= 32; j++) pushRec(0, e0 + j, tickCode(0, j), 0);
    waitDrain(60);

    phase = "div1";
    applyStimulus(1, e0);
    for (int j = 1; j <= 32; j++) pushRec(0, e0 + j, tickCode(0, j), 1);
    waitDrain(60);

    // resync lands on the 8th os_tick slot while a divisor change is pending.
    phase = "resync";
    applyStimulus(20, e0);
    for (int j = 1; j <= 7; j++) pushTick(0, e0 + 20 * j, j, 20, 20);
    pushRec(0, e0 + 159, 0, 20);
    pushRec(0, e0 + 160, 0, 20);
    for (int k = 1; k <= 16; k++) pushTick(0, e0 + 160 + 20 * k, k, 20, 20);
    waitCycle(e0 + 141);
    main_if.div_in = 16'd7;
    waitCycle(e0 + 159);
    main_if.resync = 1'b1;
    waitCycle(e0 + 160);
    main_if.resync = 1'b0;
    main_if.div_in = 16'd20;
    waitDrain(520);

    phase = "endrop";
    applyStimulus(20, e0);
    pushTick(0, e0 + 20, 1, 20, 20);
    pushRec(0, e0 + 39, 0, 20);
    pushRec(0, e0 + 40, 0, 20);
    pushRec(0, e0 + 41, 0, 20);
    e1 = e0 + 50;
    for (int j = 1; j <= 8; j++) pushTick(0, e1 + 20 * j, j, 20, 20);
    waitCycle(e0 + 39);
    main_if.en = 1'b0;
    waitCycle(e1);
    main_if.en = 1'b1;
    waitDrain(250);

    phase = "rst_async";
    applyStimulus(9, e0);
    waitCycle(e0 + 9);
    sample(0, obs_t, obs_d);
    checkOutput("pre_rst_ticks", obs_t, tickCode(0, 1));
    checkOutput("pre_rst_div", obs_d, 9);
    #2;
    rst = 1'b1;
    #1;
    sample(0, obs_t, obs_d);
    checkOutput("async_rst_ticks", obs_t, 0);
    checkOutput("async_rst_div", obs_d, 20);
    @(negedge clk);
    rst = 1'b0;
    e1 = cyc;
    pushTick(0, e1 + 20, 1, 20, 9);
    pushTick(0, e1 + 29, 2, 9, 9);
    waitDrain(60);

    phase = "sweep";
    e0 = cyc;
    sw2_if.en = 1'b1;
    sw3_if.en = 1'b1;
    sw8_if.en = 1'b1;
    for (int d = 1; d <= 3; d++) begin
      for (int j = 1; j <= 2 * osOf(d); j++) pushTick(d, e0 + 255 * j, j, 255, 255);
    end
    waitDrain(4200);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/baud_gen_os.md
Name: baud_gen_os

Overview:
- Parametrised successor to the fixed divide-by-20 baud tick generator.
- Produces three one-cycle pulses: an oversample tick every DIV clocks, and a baud tick plus a mid-bit tick at fixed positions in each group of OVERSAMPLE oversample ticks.
- DIV is a runtime-programmable divisor.
- Adds enable, glitch-free divisor update and RX start-bit phase resync. Feeds both the UART TX (baud_tick) and the oversampling RX (os_tick, mid_tick).

Parameters:
- DIV_W, 16, width of divisor input and prescale counter.
- OVERSAMPLE, 16, os_ticks per baud period; legal range 2..256.
- RST_DIV, 20, divisor loaded into the active divisor register at reset.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- en  in  1  run enable. When 0, counters are held at 0 and all ticks are 0.
- div_in  in  DIV_W  requested divisor, in clocks per os_tick. Values 0 and 1 are both treated as 1.
- resync  in  1  one-cycle pulse; realigns the bit phase (RX start-bit edge).
- os_tick  out  1  oversample tick, one-cycle pulse.
- mid_tick  out  1  pulse on the os_tick at the bit centre.
- baud_tick  out  1  pulse on the last os_tick of each bit.
- div_active  out  DIV_W  divisor currently in use.

Behaviour:
- Reset (async, immediate):
  - pre_cnt=0, sub_cnt=0.
  - div_active=RST_DIV, clamped (0 treated as 1).
  - os_tick=0, mid_tick=0, baud_tick=0.
- Outputs: all outputs are registered; there is no combinational path from any input to any output.
- div_eff = max(div_active, 1).
- Prescaler, each edge with en=1 and resync=0:
  - if pre_cnt >= div_eff-1: pre_cnt<=0, os_tick<=1.
  - else: pre_cnt<=pre_cnt+1, os_tick<=0.
  - The ">=" compare guarantees recovery if the divisor shrinks below the current count.
- Tick spacing: os_tick period is exactly div_eff clocks. The first os_tick after en rises is high in the cycle following the div_eff-th enabled edge.
- Sub counter: advances on each prescaler wrap, 0..OVERSAMPLE-1, then wraps to 0.
  - baud_tick<=1 on the wrap where sub_cnt==OVERSAMPLE-1; otherwise 0.
  - mid_tick<=1 on the wrap where sub_cnt==OVERSAMPLE/2-1 (integer division); otherwise 0.
  - Both pulses coincide with an os_tick pulse.
- Divisor update:
  - While en=0: div_active<=div_in every cycle.
  - While en=1: div_active<=div_in only on the edge where the prescaler wraps.
  - The new value governs the next os_tick period, so no period is ever truncated or mixed.
- resync (while en=1):
  - Sets pre_cnt<=0 and sub_cnt<=0 and forces all ticks to 0 that cycle.
  - resync wins over a coincident wrap: no tick is emitted and div_active is not updated.
  - The next os_tick follows div_eff clocks later.
  - The first mid_tick follows OVERSAMPLE/2 os_ticks after resync; the first baud_tick follows OVERSAMPLE os_ticks.
- resync while en=0: ignored.
- en falling: on the next edge, counters go to 0 and ticks go to 0. No residual pulse.
- Reset mid-operation: all state clears asynchronously. After rst deasserts, behaviour matches power-up.
- Tick width: ticks are never wider than 1 cycle, except os_tick when div_eff=1, where it stays high continuously (every cycle is a tick).
- Widths: pre_cnt is DIV_W bits; sub_cnt is clog2(OVERSAMPLE) bits. No arithmetic overflow is possible, because the compare precedes the increment.

Test Plan:
- Reset defaults, then run with en=1, OVERSAMPLE=16, div_in=20:
  - os_tick every 20 clocks, first after 20 edges.
  - mid_tick on the 8th os_tick, baud_tick on the 16th, then every 320 clocks.
  - div_active=20.
- Divisor change: div_in changes 20→5 midway through a prescale count:
  - the current period completes at 20 clocks; subsequent periods are 5.
  - div_active updates exactly at the wrap.
  - Repeat with 5→20 immediately after a wrap.
- div_in=0 and div_in=1:
  - os_tick is high every cycle.
  - baud_tick pulses every 16 clocks; mid_tick fires at the 8th clock.
- resync pulse driven on the same edge as a scheduled os_tick:
  - no tick that cycle.
  - next os_tick 20 clocks later.
  - mid_tick 160 clocks after resync, baud_tick 320 clocks after.
- Enable and reset interruptions:
  - Drop en mid-count: all ticks 0 and counters 0 on the next edge.
  - Re-raise en: first os_tick after a full 20 clocks.
  - Assert rst asynchronously between edges: outputs clear immediately, with no clock edge.
- Parameter sweep OVERSAMPLE∈{2,3,8}, DIV_W=8, RST_DIV=255:
  - baud_tick period = OVERSAMPLE×255 clocks.
  - mid_tick at os_tick index OVERSAMPLE/2 (1, 1, 4).
